vec_wb_collect: RTL and testbench

Write-back collector for the vector ALU lanes. Up to four `vec_alu` lanes each produce one result chunk per cycle, with a chunk bit offset (`reg_index`) and a VLEN-wide result bus. This block accepts those chunks, merges them into a single VLEN-bit destination register image, and tracks which bytes have been written. It then presents the completed `vd` to the register-file write port through a valid/ready handshake. It sits between the lane array and the vector register file.

---
 rtl/vec_wb_collect_if.sv | 39 +++
 rtl/vec_wb_collect.sv | 138 +++++++++++++
 tb/tb_vec_wb_collect.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vec_wb_collect_if.sv
// Handshake and lane bus between the vector ALU lanes, the write-back collector
// and the register-file write port.
interface vec_wb_collect_if #(
    parameter int VLEN = 128
);
    logic            start;
    logic [2:0]      vsew;
    logic [1:0]      nb_lanes;
    logic [3:0]      lane_valid;
    logic [9:0]      lane_index0;
    logic [9:0]      lane_index1;
    logic [9:0]      lane_index2;
    logic [9:0]      lane_index3;
    logic [VLEN-1:0] lane_data0;
    logic [VLEN-1:0] lane_data1;
    logic [VLEN-1:0] lane_data2;
    logic [VLEN-1:0] lane_data3;
    logic [VLEN-1:0] vd;
    logic            vd_valid;
    logic            vd_ready;
    logic            busy;
    logic            err;

    modport master (
        output start, vsew, nb_lanes, lane_valid,
        output lane_index0, lane_index1, lane_index2, lane_index3,
        output lane_data0, lane_data1, lane_data2, lane_data3,
        output vd_ready,
        input  vd, vd_valid, busy, err
    );

    modport slave (
        input  start, vsew, nb_lanes, lane_valid,
        input  lane_index0, lane_index1, lane_index2, lane_index3,
        input  lane_data0, lane_data1, lane_data2, lane_data3,
        input  vd_ready,
        output vd, vd_valid, busy, err
    );
endinterface

// File: rtl/vec_wb_collect.sv
// Merges per-lane result chunks into one VLEN-bit destination image, tracks
// written bytes and hands the finished vd to the register file.
module vec_wb_collect #(
    parameter int         VLEN       = 128,
    parameter logic [2:0] LANE_WIDTH = 3'b101
) (
    input logic           clk,
    input logic           resetn,
    vec_wb_collect_if.slave bus
);
    localparam int NB = VLEN / 8;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t          r_state;
    logic [VLEN-1:0] r_acc;
    logic [NB-1:0]   r_bitmap;
    logic [2:0]      r_vsew;
    logic [1:0]      r_nb;
    logic            r_vd_valid;
    logic            r_busy;
    logic            r_err;

    logic [3:0]      w_sew_log;
    logic [3:0]      w_wlog;
    logic [10:0]     w_wbits;
    logic [3:0]      w_lane_en;
    logic [3:0]      w_lane_act;
    logic [9:0]      w_idx [4];
    logic [VLEN-1:0] w_data [4];
    logic [10:0]     w_end [4];
    logic [3:0]      w_legal;
    logic [NB-1:0]   w_cover [4];
    logic [VLEN-1:0] w_acc_nxt;
    logic [NB-1:0]   w_bm_nxt;
    logic [NB-1:0]   w_hit;
    logic            w_err_set;

    assign w_idx[0]  = bus.lane_index0;
    assign w_idx[1]  = bus.lane_index1;
    assign w_idx[2]  = bus.lane_index2;
    assign w_idx[3]  = bus.lane_index3;
    assign w_data[0] = bus.lane_data0;
    assign w_data[1] = bus.lane_data1;
    assign w_data[2] = bus.lane_data2;
    assign w_data[3] = bus.lane_data3;

    // Chunk width is the element width capped by the lane datapath width.
    assign w_sew_log = {1'b0, r_vsew} + 4'd3;
    assign w_wlog    = (w_sew_log < {1'b0, LANE_WIDTH}) ? w_sew_log : {1'b0, LANE_WIDTH};
    assign w_wbits   = 11'd1 << w_wlog;

    assign w_lane_en  = (r_nb == 2'd0) ? 4'b0001 : (r_nb == 2'd1) ? 4'b0011 : 4'b1111;
    assign w_lane_act = bus.lane_valid & w_lane_en;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_end[i]   = {1'b0, w_idx[i]} + w_wbits;
        assign w_legal[i] = ((w_idx[i] & (w_wbits[9:0] - 10'd1)) == 10'd0) &&
                            (w_end[i] <= 11'(VLEN));
        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign w_cover[i][b] = (11'(b) >= {4'b0, w_idx[i][9:3]}) &&
                                   (11'(b) < ({4'b0, w_idx[i][9:3]} + {3'b0, w_wbits[10:3]}));
        end
    end

    // Lanes are merged in ascending order so the highest lane wins a collision.
    always_comb begin
        w_acc_nxt = r_acc;
        w_bm_nxt  = r_bitmap;
        w_hit     = '0;
        w_err_set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_lane_act[i]) begin
                if (!w_legal[i]) begin
                    w_err_set = 1'b1;
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_cover[i][b]) begin
                            if (w_hit[b] || r_bitmap[b]) w_err_set = 1'b1;
                            w_hit[b]            = 1'b1;
                            w_bm_nxt[b]         = 1'b1;
                            w_acc_nxt[8*b +: 8] = w_data[i][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_bitmap   <= '0;
            r_vsew     <= 3'd0;
            r_nb       <= 2'd0;
            r_vd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc    <= '0;
                        r_bitmap <= '0;
                        r_err    <= 1'b0;
                        r_vsew   <= bus.vsew;
                        r_nb     <= (bus.nb_lanes == 2'd3) ? 2'd2 : bus.nb_lanes;
                        r_busy   <= 1'b1;
                        r_state  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    r_acc    <= w_acc_nxt;
                    r_bitmap <= w_bm_nxt;
                    if (w_err_set) r_err <= 1'b1;
                    if (&w_bm_nxt) begin
                        r_vd_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.vd_ready) begin
                        r_vd_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.vd       = r_acc;
    assign bus.vd_valid = r_vd_valid;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_vec_wb_collect.sv
// Directed table-driven bench for vec_wb_collect plus hand-written backpressure
// and mid-collect reset sequences.
module tb_vec_wb_collect;
    localparam logic [127:0] Z  = 128'h0;
    localparam logic [127:0] V1 = 128'h3332eeeed1241567d12415673332eeee;
    localparam logic [127:0] V2 = 128'h3232eeeed0231467d02314673232eeee;

    typedef struct {
        string        name;
        logic         st;
        logic [2:0]   vsew;
        logic [1:0]   nb;
        logic [3:0]   lv;
        logic [9:0]   i0, i1, i2, i3;
        logic [127:0] d0, d1, d2, d3;
        logic         rdy;
        logic [127:0] evd;
        logic         ev, eb, ee;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    vec_t vecs[$];

    vec_wb_collect_if #(.VLEN(128)) bus ();

    vec_wb_collect #(.VLEN(128), .LANE_WIDTH(3'b101)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic st, input logic [2:0] vsew,
                                input logic [1:0] nb, input logic [3:0] lv,
                                input int i0, input int i1, input int i2, input int i3,
                                input logic [127:0] d0, input logic [127:0] d1,
                                input logic [127:0] d2, input logic [127:0] d3,
                                input logic rdy, input logic [127:0] evd,
                                input logic ev, input logic eb, input logic ee);
        vec_t v;
        v.name = name; v.st = st; v.vsew = vsew; v.nb = nb; v.lv = lv;
        v.i0 = 10'(i0); v.i1 = 10'(i1); v.i2 = 10'(i2); v.i3 = 10'(i3);
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.rdy = rdy; v.evd = evd; v.ev = ev; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] vsew, input logic [1:0] nb,
                         input logic [3:0] lv, input int i0, input int i1, input int i2,
                         input int i3, input logic [127:0] d, input logic rdy);
        bus.start = st; bus.vsew = vsew; bus.nb_lanes = nb; bus.lane_valid = lv;
        bus.lane_index0 = 10'(i0); bus.lane_index1 = 10'(i1);
        bus.lane_index2 = 10'(i2); bus.lane_index3 = 10'(i3);
        bus.lane_data0 = d; bus.lane_data1 = d; bus.lane_data2 = d; bus.lane_data3 = d;
        bus.vd_ready = rdy;
    endtask

    task automatic chk_all(input string nm, input logic [127:0] evd, input logic ev,
                           input logic eb, input logic ee);
        chk({nm, ".vd"}, bus.vd, evd);
        chk({nm, ".vd_valid"}, 128'(bus.vd_valid), 128'(ev));
        chk({nm, ".busy"}, 128'(bus.busy), 128'(eb));
        chk({nm, ".err"}, 128'(bus.err), 128'(ee));
    endtask

    initial begin
        // Test 1: 32b, two lanes
        vecs.push_back(mk("a_start", 1, 2, 1, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, Z, 0, 1, 0));
        vecs.push_back(mk("a_c0", 0, 2, 1, 4'b0011, 0, 32, 0, 0, V1, V1, Z, Z, 1, 128'hd12415673332eeee, 0, 1, 0));
        vecs.push_back(mk("a_c1", 0, 2, 1, 4'b0011, 64, 96, 0, 0, V1, V1, Z, Z, 1, V1, 1, 1, 0));
        vecs.push_back(mk("a_hs", 0, 2, 1, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, V1, 0, 0, 0));
        // Test 2: 8b, four lanes
        vecs.push_back(mk("b_start", 1, 0, 2, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, Z, 0, 1, 0));
        vecs.push_back(mk("b_c0", 0, 0, 2, 4'b1111, 0, 8, 16, 24, V2, V2, V2, V2, 1, 128'h3232eeee, 0, 1, 0));
        vecs.push_back(mk("b_c1", 0, 0, 2, 4'b1111, 32, 40, 48, 56, V2, V2, V2, V2, 1, 128'hd02314673232eeee, 0, 1, 0));
        vecs.push_back(mk("b_c2", 0, 0, 2, 4'b1111, 64, 72, 80, 88, V2, V2, V2, V2, 1, 128'h00000000d0231467d02314673232eeee, 0, 1, 0));
        vecs.push_back(mk("b_c3", 0, 0, 2, 4'b1111, 96, 104, 112, 120, V2, V2, V2, V2, 1, V2, 1, 1, 0));
        vecs.push_back(mk("b_hs", 0, 0, 2, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, V2, 0, 0, 0));
        // Test 3: inactive lane ignored, then illegal indices dropped
        vecs.push_back(mk("c_start", 1, 2, 0, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, Z, 0, 1, 0));
        vecs.push_back(mk("c_ign", 0, 2, 0, 4'b0010, 0, 0, 0, 0, Z, ~Z, Z, Z, 1, Z, 0, 1, 0));
        vecs.push_back(mk("c_bad128", 0, 2, 0, 4'b0001, 128, 0, 0, 0, V1, Z, Z, Z, 1, Z, 0, 1, 1));
        vecs.push_back(mk("c_bad130", 0, 2, 0, 4'b0001, 130, 0, 0, 0, V1, Z, Z, Z, 1, Z, 0, 1, 1));
        vecs.push_back(mk("c_bad4", 0, 2, 0, 4'b0001, 4, 0, 0, 0, V1, Z, Z, Z, 1, Z, 0, 1, 1));
        vecs.push_back(mk("c_f0", 0, 2, 0, 4'b0001, 0, 0, 0, 0, V1, Z, Z, Z, 1, 128'h3332eeee, 0, 1, 1));
        vecs.push_back(mk("c_f1", 0, 2, 0, 4'b0001, 32, 0, 0, 0, V1, Z, Z, Z, 1, 128'hd12415673332eeee, 0, 1, 1));
        vecs.push_back(mk("c_f2", 0, 2, 0, 4'b0001, 64, 0, 0, 0, V1, Z, Z, Z, 1, 128'h00000000d1241567d12415673332eeee, 0, 1, 1));
        vecs.push_back(mk("c_f3", 0, 2, 0, 4'b0001, 96, 0, 0, 0, V1, Z, Z, Z, 1, V1, 1, 1, 1));
        vecs.push_back(mk("c_hs", 0, 2, 0, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, V1, 0, 0, 1));
        // Test 4: same-cycle collision, nb_lanes=3 acts as four lanes
        vecs.push_back(mk("d_start", 1, 2, 3, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, Z, 0, 1, 0));
        vecs.push_back(mk("d_col", 0, 2, 3, 4'b1111, 0, 0, 32, 64, 128'h11111111, 128'h22222222, 128'h3333333300000000, 128'h444444440000000000000000, 1, 128'h00000000444444443333333322222222, 0, 1, 1));
        vecs.push_back(mk("d_last", 0, 2, 3, 4'b0001, 96, 0, 0, 0, 128'h55555555000000000000000000000000, Z, Z, Z, 1, 128'h55555555444444443333333322222222, 1, 1, 1));
        vecs.push_back(mk("d_hs", 0, 2, 3, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, 128'h55555555444444443333333322222222, 0, 0, 1));
        // 64b elements still use 32-bit chunks; rewriting a chunk flags err
        vecs.push_back(mk("e_start", 1, 3, 0, 4'b0000, 0, 0, 0, 0, Z, Z, Z, Z, 1, Z, 0, 1, 0));
        vecs.push_back(mk("e_w0", 0, 3, 0, 4'b0001, 0, 0, 0, 0, 128'hccccccccaaaaaaaa, Z, Z, Z, 1, 128'haaaaaaaa, 0, 1, 0));
        vecs.push_back(mk("e_rw", 0, 3, 0, 4'b0001, 0, 0, 0, 0, 128'hccccccccbbbbbbbb, Z, Z, Z, 1, 128'hbbbbbbbb, 0, 1, 1));

        drive(0, 0, 0, 4'b0000, 0, 0, 0, 0, Z, 1);
        #1;
        chk_all("reset", Z, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            bus.start = vecs[k].st; bus.vsew = vecs[k].vsew; bus.nb_lanes = vecs[k].nb;
            bus.lane_valid = vecs[k].lv;
            bus.lane_index0 = vecs[k].i0; bus.lane_index1 = vecs[k].i1;
            bus.lane_index2 = vecs[k].i2; bus.lane_index3 = vecs[k].i3;
            bus.lane_data0 = vecs[k].d0; bus.lane_data1 = vecs[k].d1;
            bus.lane_data2 = vecs[k].d2; bus.lane_data3 = vecs[k].d3;
            bus.vd_ready = vecs[k].rdy;
            @(posedge clk);
            #1;
            chk_all(vecs[k].name, vecs[k].evd, vecs[k].ev, vecs[k].eb, vecs[k].ee);
        end

        // Clean restart from a collection left open by the table
        @(negedge clk);
        resetn = 1'b0;
        drive(0, 0, 0, 4'b0000, 0, 0, 0, 0, Z, 0);
        #1;
        chk_all("rst_open", Z, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Test 5: backpressure with start pulsed during DONE
        drive(1, 2, 2, 4'b0000, 0, 0, 0, 0, Z, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 2, 2, 4'b1111, 0, 32, 64, 96, V1, 0);
        @(posedge clk);
        #1;
        chk_all("bp_fill", V1, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(k == 1, 0, 0, 4'b1111, 0, 32, 64, 96, ~V1, 0);
            @(posedge clk);
            #1;
            chk_all($sformatf("bp_hold%0d", k), V1, 1, 1, 0);
        end
        @(negedge clk);
        drive(1, 2, 2, 4'b0000, 0, 0, 0, 0, Z, 1);
        @(posedge clk);
        #1;
        chk_all("bp_hs", V1, 0, 0, 0);
        @(negedge clk);
        drive(0, 2, 2, 4'b0000, 0, 0, 0, 0, Z, 1);
        @(posedge clk);
        #1;
        chk_all("bp_idle", V1, 0, 0, 0);

        // Test 6: asynchronous reset in the middle of a collection
        @(negedge clk);
        drive(1, 2, 0, 4'b0000, 0, 0, 0, 0, Z, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 2, 0, 4'b0001, 0, 0, 0, 0, V1, 1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 2, 0, 4'b0001, 32, 0, 0, 0, V1, 1);
        @(posedge clk);
        #1;
        chk_all("mr_half", 128'hd12415673332eeee, 0, 1, 0);
        @(negedge clk);
        drive(0, 2, 0, 4'b0001, 4, 0, 0, 0, V1, 1);
        @(posedge clk);
        #1;
        chk_all("mr_bad", 128'hd12415673332eeee, 0, 1, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("mr_async", Z, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 2, 2, 4'b0000, 0, 0, 0, 0, Z, 1);
        @(posedge clk);
        #1;
        chk_all("mr_start", Z, 0, 1, 0);
        @(negedge clk);
        drive(0, 2, 2, 4'b1111, 0, 32, 64, 96, V1, 1);
        @(posedge clk);
        #1;
        chk_all("mr_full", V1, 1, 1, 0);
        @(negedge clk);
        drive(0, 2, 2, 4'b0000, 0, 0, 0, 0, Z, 1);
        @(posedge clk);
        #1;
        chk_all("mr_hs", V1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
